// File: rtl/multiplier_pkg.sv
// multiplier_pkg: FSM state type and sizing constants shared by the shift-add multiplier
package multiplier_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int OPERAND_W_DEF = 8;
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    localparam int CNT_W_DEF = cnt_width(OPERAND_W_DEF);
endpackage

// File: rtl/mult_datapath.sv
// mult_datapath: operand/accumulator registers and the OPERAND_W+1 bit shift-add step (MULTIPLIER_SIGNED_EN adds sign handling)
module mult_datapath import multiplier_pkg::*; #(
    parameter int OPERAND_W = OPERAND_W_DEF
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   i_load,
    input  logic                   i_step,
    input  logic                   i_load_result,
    input  logic [OPERAND_W-1:0]   i_operand1,
    input  logic [OPERAND_W-1:0]   i_operand2,
    output logic [2*OPERAND_W-1:0] o_product
);
    logic [OPERAND_W-1:0]   r_mcand;
    logic [OPERAND_W-1:0]   r_acc;
    logic [OPERAND_W-1:0]   r_mplier;
    logic [2*OPERAND_W-1:0] r_product;
    logic [OPERAND_W:0]     w_sum;
    logic [OPERAND_W-1:0]   w_acc_nxt;
    logic [OPERAND_W-1:0]   w_mplier_nxt;
    logic [OPERAND_W-1:0]   w_op1;
    logic [OPERAND_W-1:0]   w_op2;
    logic [2*OPERAND_W-1:0] w_result;
`ifdef MULTIPLIER_SIGNED_EN
    logic r_neg;
    // magnitudes feed the unsigned core; the sign is reapplied as the result is loaded
    always_comb begin
        w_op1    = i_operand1[OPERAND_W-1] ? -i_operand1 : i_operand1;
        w_op2    = i_operand2[OPERAND_W-1] ? -i_operand2 : i_operand2;
        w_result = r_neg ? -{w_acc_nxt, w_mplier_nxt} : {w_acc_nxt, w_mplier_nxt};
    end
    // remember whether the operand signs differ
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)     r_neg <= 1'b0;
        else if (i_load) r_neg <= i_operand1[OPERAND_W-1] ^ i_operand2[OPERAND_W-1];
    end
`else
    assign w_op1    = i_operand1;
    assign w_op2    = i_operand2;
    assign w_result = {w_acc_nxt, w_mplier_nxt};
`endif
    // one step: conditional add into the upper half, then shift {carry, acc, mplier} right
    always_comb begin
        w_sum        = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        w_acc_nxt    = w_sum[OPERAND_W:1];
        w_mplier_nxt = {w_sum[0], r_mplier[OPERAND_W-1:1]};
    end
    // working registers: loaded on accept, advanced on each step
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_mcand  <= w_op1;
            r_acc    <= '0;
            r_mplier <= w_op2;
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= w_mplier_nxt;
        end
    end
    // product captures the final step's outcome and holds until the next completion
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)            r_product <= '0;
        else if (i_load_result) r_product <= w_result;
    end
    assign o_product = r_product;
endmodule

// File: rtl/multiplier.sv
// multiplier: sequential shift-add multiplier, IDLE/CALC/DONE control; define MULTIPLIER_SIGNED_EN for two's-complement operands
module multiplier import multiplier_pkg::*; #(
    parameter int OPERAND_W = OPERAND_W_DEF
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic [OPERAND_W-1:0]   Operand1,
    input  logic [OPERAND_W-1:0]   Operand2,
    input  logic                   Req,
    output logic [2*OPERAND_W-1:0] Product,
    output logic                   Done,
    output logic                   Busy
);
    localparam int CNT_W = cnt_width(OPERAND_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OPERAND_W - 1);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_step;
    logic             w_load_result;
    // state register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end
    // next state and datapath controls; Req only matters in IDLE
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_load_result = 1'b0;
        case (r_state)
            IDLE: begin
                w_load      = Req;
                w_state_nxt = Req ? CALC : IDLE;
            end
            CALC: begin
                w_step        = 1'b1;
                w_load_result = (r_cnt == LAST);
                w_state_nxt   = (r_cnt == LAST) ? DONE : CALC;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    // iteration counter: cleared on accept, one count per step
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)     r_cnt <= '0;
        else if (w_load) r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + 1'b1;
    end
    mult_datapath #(.OPERAND_W(OPERAND_W)) u_dp (
        .Clock         (Clock),
        .nReset        (nReset),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_load_result (w_load_result),
        .i_operand1    (Operand1),
        .i_operand2    (Operand2),
        .o_product     (Product)
    );
    assign Done = (r_state == DONE);
    assign Busy = (r_state != IDLE);
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: randomized and directed checks of multiplier against an arithmetic reference
module tb_multiplier;
    localparam int W = 8;
    logic           Clock = 1'b0;
    logic           nReset = 1'b0;
    logic           Req = 1'b0;
    logic [W-1:0]   Operand1 = '0;
    logic [W-1:0]   Operand2 = '0;
    logic [2*W-1:0] Product;
    logic           Done;
    logic           Busy;
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    multiplier #(.OPERAND_W(W)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Req      (Req),
        .Product  (Product),
        .Done     (Done),
        .Busy     (Busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
`ifdef MULTIPLIER_SIGNED_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        Operand1 = a;
        Operand2 = b;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        Operand1 = W'($urandom);
        Operand2 = W'($urandom);
        check({tag, " busy"}, Busy, 1);
        wait_done(lat);
        check({tag, " latency"}, lat, W);
        check({tag, " product"}, Product, ref_mul(a, b));
        tick();
        check({tag, " done_pulse"}, Done, 0);
        check({tag, " idle"}, Busy, 0);
    endtask

    initial begin
        int lat;
        int n;
        #1;
        check("rst product", Product, 0);
        check("rst done", Done, 0);
        check("rst busy", Busy, 0);
        tick();
        nReset = 1'b1;
        tick();

        run_op("13x11", 8'd13, 8'd11);
        check("13x11 const", Product, 16'h008F);
        run_op("255x255", 8'd255, 8'd255);
        run_op("0x200", 8'd0, 8'd200);
`ifdef MULTIPLIER_SIGNED_EN
        run_op("m3x5", 8'hFD, 8'd5);
        check("m3x5 const", Product, 16'hFFF1);
        run_op("m128xm128", 8'h80, 8'h80);
        check("m128xm128 const", Product, 16'h4000);
        run_op("127xm1", 8'd127, 8'hFF);
        check("127xm1 const", Product, 16'hFF81);
`else
        check("0x200 const", Product, 16'h0000);
        run_op("255x255b", 8'd255, 8'd255);
        check("255x255 const", Product, 16'hFE01);
`endif

        Operand1 = 8'd3;
        Operand2 = 8'd4;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        repeat (3) tick();
        Operand1 = 8'd7;
        Operand2 = 8'd7;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        wait_done(lat);
        check("busy_ign latency", lat, W - 4);
        check("busy_ign product", Product, 16'd12);
        n = 0;
        repeat (15) begin
            tick();
            if (Done) n++;
        end
        check("busy_ign no_queue", n, 0);

        Operand1 = 8'd5;
        Operand2 = 8'd6;
        Req = 1'b1;
        tick();
        wait_done(lat);
        check("held first latency", lat, W);
        check("held first product", Product, 16'd30);
        repeat (2) begin
            tick();
            wait_done(lat);
            check("held spacing", lat + 1, W + 2);
            check("held product", Product, 16'd30);
        end
        Req = 1'b0;
        tick();
        tick();
        check("held stop", Busy, 0);

        Operand1 = 8'd200;
        Operand2 = 8'd3;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        repeat (4) tick();
        check("abort in calc", Busy, 1);
        #2;
        nReset = 1'b0;
        #1;
        check("abort product", Product, 0);
        check("abort done", Done, 0);
        check("abort busy", Busy, 0);
        tick();
        nReset = 1'b1;
        tick();
        check("post_rst product", Product, 0);
        run_op("2x3", 8'd2, 8'd3);
        check("2x3 const", Product, 16'd6);

        run_op("9x9", 8'd9, 8'd9);
        n = 0;
        repeat (20) begin
            Operand1 = W'($urandom);
            Operand2 = W'($urandom);
            tick();
            if (Product !== ref_mul(8'd9, 8'd9) || Busy) n++;
        end
        check("hold bad_cycles", n, 0);
        check("hold product", Product, 16'd81);

        repeat (25) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_op("rand", a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
